switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Front-end conditioning stage for the lab board's slide switches. It sits directly upstream of the `main` logic block and drives its `switch[7:0]` bus.
- Each bit goes through a 2-flop synchronizer and then a stability counter. A bit's output changes only after its input has held a new level for STABLE_CYCLES consecutive clocks.
- The block also produces single-cycle rise/fall pulses for later sequential labs.

Parameters:
- WIDTH, 8: number of switch bits conditioned.
- STABLE_CYCLES, 4: consecutive clocks a changed level must hold before `sw_out` updates. Use 4 in simulation; the board build uses 500000 (10 ms at 50 MHz).
- CNT_W, $clog2(STABLE_CYCLES+1): counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  asynchronous switch pins.
- sw_out  out  WIDTH  debounced level; connects to `main.switch`.
- sw_rise  out  WIDTH  one-cycle pulse per bit when `sw_out` goes 0->1.
- sw_fall  out  WIDTH  one-cycle pulse per bit when `sw_out` goes 1->0.
- any_change  out  1  OR-reduction of (sw_rise | sw_fall), registered with the pulses.

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous and active-high. While rst=1 at a clock edge, all of the following load 0: sync1, sync2, sw_out, sw_rise, sw_fall, any_change, every counter, and every per-bit state (IDLE).
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. No other logic reads sync1.
- Per-bit FSM, 2 states:
  - IDLE (cnt=0): if sync2[i] != sw_out[i], go to COUNT with cnt=1. Otherwise stay.
  - COUNT: if sync2[i] == sw_out[i], the bounce is rejected; return to IDLE with cnt=0.
  - COUNT: else if cnt == STABLE_CYCLES-1, set sw_out[i] <= sync2[i], fire the matching pulse, return to IDLE with cnt=0.
  - COUNT: else cnt <= cnt+1.
- Latency: a clean level change on sw_raw[i], set up before edge k, appears on sw_out[i] after edge k+1+STABLE_CYCLES. With the default of 4, that is 6 edges total.
- Pulses: sw_rise/sw_fall are high exactly in the cycle where sw_out changes, then return to 0 on the next edge. Rise and fall on the same bit can never coincide.
- Bits are fully independent. Simultaneous transitions on several bits produce pulses in the same cycle.
- Input glitch shorter than STABLE_CYCLES (measured at sync2): no sw_out change, no pulse.
- A glitch exactly STABLE_CYCLES long is accepted.
- Counter never wraps. It saturates by construction because it clears at STABLE_CYCLES-1.
- Reset mid-count: the counter is discarded and sw_out stays 0. After release, counting restarts from sync2. The synchronizer was also cleared, so the first recount begins 2 edges later.
- Switches held high through reset: sw_out rises after release with the normal latency, and sw_rise pulses once.
- STABLE_CYCLES=1: sw_out follows sync2 with 1 cycle of delay; pulses still fire.

Decomposition:
- Shared package `lab_pkg`:
  - SW_WIDTH = 8
  - SIM_STABLE_CYCLES = 4
  - BOARD_STABLE_CYCLES = 500000
  - enum type `db_state_t` {DB_IDLE, DB_COUNT}
- Sub-module `debounce_bit`:
  - Holds one synchronizer chain, FSM, counter, level and pulse regs.
  - Instantiated WIDTH times via generate.
- Top level owns only the any_change OR-reduction register.

Test Plan (STABLE_CYCLES=4):
- rst=1 for 3 edges with sw_raw=8'hFF, then release -> sw_out=8'h00 for edges 1-5 after release. Edge 6 gives sw_out=8'hFF, sw_rise=8'hFF, any_change=1 for one cycle, then sw_rise=0.
- From steady 8'h00, sw_raw[0]=1 for 3 cycles then 0 -> sw_out stays 8'h00; sw_rise, sw_fall and any_change stay 0 throughout.
- Bounce bit3 as 1,0,1,1,0 then hold 1 -> sw_out[3] rises exactly 6 edges after the final 0->1 on sw_raw[3]. Exactly one sw_rise[3] pulse; no sw_fall[3].
- From sw_out=8'h02, change sw_raw to 8'h40 in one cycle -> after 6 edges sw_out=8'h40, with sw_fall=8'h02 and sw_rise=8'h40 in the same cycle.
- sw_raw=8'h01; assert rst 4 edges later (counter mid-run) for 1 edge -> sw_out[0]=0 at reset. It rises 6 edges after rst deasserts, not earlier.
- Integration: chain into `main` and sweep sw_raw 8'h00..8'hFE, each held 10 cycles -> at the 7th cycle of each hold, sw_out equals the held value. The existing `main` checks report 0 errors.

Source files
------------

// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab_pkg
// Purpose  : Shared constants and types for the lab board front-end logic.
//            SW_WIDTH            - number of slide switches on the board
//            SIM_STABLE_CYCLES   - short debounce window used in simulation
//            BOARD_STABLE_CYCLES - 10 ms at 50 MHz for the real board build
//            db_state_t          - per-bit debounce FSM state
// Revision : 1.0 - initial release
// ============================================================================
package lab_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int SIM_STABLE_CYCLES   = 4;
  localparam int BOARD_STABLE_CYCLES = 500000;

  typedef enum logic [0:0] {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage : lab_pkg
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_if
// Purpose  : Bundles the raw switch pins and the conditioned outputs.
//            sw_raw     - asynchronous switch pins (into the debouncer)
//            sw_out     - debounced level
//            sw_rise    - one-cycle pulse per bit on sw_out 0->1
//            sw_fall    - one-cycle pulse per bit on sw_out 1->0
//            any_change - OR of all rise/fall pulses, same cycle as pulses
//            master modport: the debouncer; slave modport: the consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if
  import lab_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;

  modport master (
    input  sw_raw,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output any_change
  );

  modport slave (
    output sw_raw,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  any_change
  );

endinterface : switch_debouncer_if
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : One switch bit: 2-flop synchronizer, stability counter FSM,
//            registered level and registered rise/fall pulses.
//            clk, rst  - system clock, synchronous active-high reset
//            sw_raw    - asynchronous pin
//            sw_out    - debounced level
//            sw_rise   - pulse when sw_out goes 0->1
//            sw_fall   - pulse when sw_out goes 1->0
//            change    - combinational "level accepted this cycle" flag, lets
//                        the parent register any_change alongside the pulses
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
  import lab_pkg::*;
#(
  parameter int STABLE_CYCLES = SIM_STABLE_CYCLES
) (
  input  wire  logic clk,
  input  wire  logic rst,
  input  wire  logic sw_raw,
  output logic       sw_out,
  output logic       sw_rise,
  output logic       sw_fall,
  output logic       change
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             out_q,   out_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic             accept;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    case (state_q)
      DB_IDLE: begin
        if (sync2_q != out_q) begin
          // A one-cycle window means the first differing sample is enough.
          if (STABLE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = DB_COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DB_COUNT: begin
        if (sync2_q == out_q) begin
          // Input bounced back before the window closed: discard.
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Clearing here is what keeps the counter from ever wrapping.
          accept  = 1'b1;
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase

    out_d  = accept ? sync2_q : out_q;
    rise_d = accept &  sync2_q;
    fall_d = accept & ~sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_out  = out_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  assign change  = accept;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Purpose  : Debounces WIDTH slide switches ahead of the main lab logic.
//            clk, rst - system clock, synchronous active-high reset
//            bus      - switch_debouncer_if master: sw_raw in; sw_out,
//                       sw_rise, sw_fall, any_change out
//            Each bit is an independent debounce_bit; this level only owns
//            the any_change register.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
  import lab_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = SIM_STABLE_CYCLES
) (
  input  wire logic          clk,
  input  wire logic          rst,
  switch_debouncer_if.master bus
);

  logic [WIDTH-1:0] sw_out_w;
  logic [WIDTH-1:0] sw_rise_w;
  logic [WIDTH-1:0] sw_fall_w;
  logic [WIDTH-1:0] change_w;
  logic             any_change_q, any_change_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .sw_raw  (bus.sw_raw[i]),
      .sw_out  (sw_out_w[i]),
      .sw_rise (sw_rise_w[i]),
      .sw_fall (sw_fall_w[i]),
      .change  (change_w[i])
    );
  end

  // Built from the pre-register accept flags so it lands with the pulses.
  always_comb begin
    any_change_d = |change_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= any_change_d;
    end
  end

  assign bus.sw_out     = sw_out_w;
  assign bus.sw_rise    = sw_rise_w;
  assign bus.sw_fall    = sw_fall_w;
  assign bus.any_change = any_change_q;

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Purpose  : Self-checking bench for switch_debouncer. A run-length reference
//            model (consecutive mismatching synchronized samples) predicts
//            every output each cycle; directed steps add fixed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;
  import lab_pkg::*;

  localparam int W  = SW_WIDTH;
  localparam int SC = SIM_STABLE_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: input history per edge, level, pulses, run lengths.
  logic [W-1:0] raw_h[$];
  bit           rst_h[$];
  logic [W-1:0] m_out  = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  int           run[W];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge with the given inputs, advance the model, compare.
  task automatic step(input logic [W-1:0] raw, input bit r);
    logic [W-1:0] s;
    int e;
    sw_if.sw_raw = raw;
    rst          = r;
    @(posedge clk);
    e = raw_h.size();
    // Level seen after the two-stage synchronizer: pin value two edges ago,
    // or zero if a reset hit either of the last two edges.
    s = (e >= 2 && !rst_h[e-1] && !rst_h[e-2]) ? raw_h[e-2] : '0;
    raw_h.push_back(raw);
    rst_h.push_back(r);
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_out = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (s[i] !== m_out[i]) begin
          run[i]++;
          if (run[i] == SC) begin
            m_out[i]  = s[i];
            m_rise[i] = s[i];
            m_fall[i] = ~s[i];
            run[i]    = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    #1;
    check("model_sw_out",  sw_if.sw_out,  m_out);
    check("model_sw_rise", sw_if.sw_rise, m_rise);
    check("model_sw_fall", sw_if.sw_fall, m_fall);
    check("model_any",     {{(W-1){1'b0}}, sw_if.any_change}, {{(W-1){1'b0}}, |(m_rise | m_fall)});
  endtask

  initial begin
    logic [4:0]   bounce;
    logic [W-1:0] v;
    int           h;
    bit           r;

    sw_if.sw_raw = '0;

    // Switches held high through reset.
    repeat (3) step(8'hFF, 1'b1);
    check("reset_out", sw_if.sw_out, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      step(8'hFF, 1'b0);
      check("rel_wait_out", sw_if.sw_out, 8'h00);
    end
    step(8'hFF, 1'b0);
    check("rel_out",  sw_if.sw_out,  8'hFF);
    check("rel_rise", sw_if.sw_rise, 8'hFF);
    check("rel_any",  {7'b0, sw_if.any_change}, 8'h01);
    step(8'hFF, 1'b0);
    check("rel_rise_clear", sw_if.sw_rise, 8'h00);

    // Short glitch on bit 0 is rejected.
    repeat (10) step(8'h00, 1'b0);
    check("glitch_pre", sw_if.sw_out, 8'h00);
    repeat (3) step(8'h01, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(8'h00, 1'b0);
      check("glitch_quiet", sw_if.sw_out | sw_if.sw_rise | sw_if.sw_fall, 8'h00);
    end

    // Bounce on bit 3: 1,0,1,1,0 then hold 1.
    bounce = 5'b10110;
    for (int k = 4; k >= 0; k--) step(bounce[k] ? 8'h08 : 8'h00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(8'h08, 1'b0);
      check("bounce_wait", {7'b0, sw_if.sw_out[3]}, 8'h00);
    end
    step(8'h08, 1'b0);
    check("bounce_out",  {7'b0, sw_if.sw_out[3]},  8'h01);
    check("bounce_rise", {7'b0, sw_if.sw_rise[3]}, 8'h01);
    for (int k = 0; k < 5; k++) begin
      step(8'h08, 1'b0);
      check("bounce_single", {6'b0, sw_if.sw_rise[3], sw_if.sw_fall[3]}, 8'h00);
    end

    // Simultaneous fall on bit 1 and rise on bit 6.
    repeat (10) step(8'h02, 1'b0);
    check("multi_pre", sw_if.sw_out, 8'h02);
    for (int k = 1; k <= 5; k++) begin
      step(8'h40, 1'b0);
      check("multi_wait", sw_if.sw_out, 8'h02);
    end
    step(8'h40, 1'b0);
    check("multi_out",  sw_if.sw_out,  8'h40);
    check("multi_fall", sw_if.sw_fall, 8'h02);
    check("multi_rise", sw_if.sw_rise, 8'h40);
    check("multi_any",  {7'b0, sw_if.any_change}, 8'h01);

    // Reset while the bit-0 counter is mid-run.
    repeat (10) step(8'h00, 1'b0);
    repeat (4) step(8'h01, 1'b0);
    step(8'h01, 1'b1);
    check("midrst_out", sw_if.sw_out, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      step(8'h01, 1'b0);
      check("midrst_wait", sw_if.sw_out, 8'h00);
    end
    step(8'h01, 1'b0);
    check("midrst_out_rise", sw_if.sw_out, 8'h01);

    // Randomized holds with occasional resets.
    for (int n = 0; n < 400; n++) begin
      v = W'($urandom);
      h = int'($urandom_range(1, 8));
      r = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < h; j++) step(v, r && (j == 0));
    end

    // Sweep of held values as seen by the downstream logic.
    for (int s = 0; s < 255; s++) begin
      for (int c = 1; c <= 10; c++) begin
        step(W'(s), 1'b0);
        if (c == 7) check("sweep_out", sw_if.sw_out, W'(s));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_switch_debouncer
`default_nettype wire
